// File: rtl/btn_event_arbiter.sv
// Turns debounced button levels into press / auto-repeat events, holds one pending
// event per button and offers them round-robin on a single valid/ready port.
module btn_event_arbiter #(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter logic [3:0]  REPEAT_MASK   = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_db,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic       evt_repeat,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [31:0] DELAY_M1  = REPEAT_DELAY - 32'd1;
    localparam logic [31:0] PERIOD_M1 = REPEAT_PERIOD - 32'd1;

    state_t      state_q, state_d;
    logic [3:0]  btn_prev_q;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  rep_q, rep_d;
    logic        overflow_q, overflow_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic        evt_valid_q, evt_valid_d;
    logic [1:0]  evt_id_q, evt_id_d;
    logic        evt_repeat_q, evt_repeat_d;
    logic [31:0] timer_q, timer_d;
    logic        phase_q, phase_d;

    logic [3:0]  rise;
    logic [3:0]  masked_held;
    logic        masked_edge;
    logic [1:0]  rep_id;
    logic        rep_found;
    logic        rep_tick;
    logic [31:0] timer_limit;
    logic [1:0]  grant_id;
    logic [1:0]  scan_idx;
    logic        grant_found;
    logic [3:0]  take;
    logic [3:0]  set_req;

    assign rise        = btn_db & ~btn_prev_q;
    assign masked_held = btn_db & REPEAT_MASK;
    assign masked_edge = |((btn_db ^ btn_prev_q) & REPEAT_MASK);
    assign timer_limit = phase_q ? PERIOD_M1 : DELAY_M1;

    // Auto-repeat: one shared timer follows the lowest-index held masked button.
    always_comb begin
        rep_id    = '0;
        rep_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (masked_held[i] && !rep_found) begin
                rep_id    = 2'(i);
                rep_found = 1'b1;
            end
        end

        rep_tick = 1'b0;
        timer_d  = timer_q;
        phase_d  = phase_q;
        if (masked_held == '0 || masked_edge) begin
            timer_d = '0;
            phase_d = 1'b0;
        end else if (timer_q == timer_limit) begin
            rep_tick = 1'b1;
            timer_d  = '0;
            phase_d  = 1'b1;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Round-robin scan starting just after the last granted button.
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            scan_idx = last_grant_q + 2'(k);
            if (pending_q[scan_idx] && !grant_found) begin
                grant_id    = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        evt_repeat_d = evt_repeat_q;
        take         = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    take[grant_id] = 1'b1;
                    evt_valid_d    = 1'b1;
                    evt_id_d       = grant_id;
                    evt_repeat_d   = rep_q[grant_id];
                    state_d        = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    evt_valid_d  = 1'b0;
                    last_grant_d = evt_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new request beats a same-cycle take; it only merges when nothing frees the slot.
    always_comb begin
        pending_d  = pending_q;
        rep_d      = rep_q;
        overflow_d = overflow_q;
        set_req    = rise;
        if (rep_tick) begin
            set_req[rep_id] = 1'b1;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (set_req[i]) begin
                pending_d[i] = 1'b1;
                rep_d[i]     = ~rise[i];
                if (pending_q[i] && !take[i]) begin
                    overflow_d = 1'b1;
                end
            end else if (take[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            btn_prev_q   <= '0;
            pending_q    <= '0;
            rep_q        <= '0;
            overflow_q   <= 1'b0;
            last_grant_q <= 2'd3;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_repeat_q <= 1'b0;
            timer_q      <= '0;
            phase_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= btn_db;
            pending_q    <= pending_d;
            rep_q        <= rep_d;
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_repeat_q <= evt_repeat_d;
            timer_q      <= timer_d;
            phase_q      <= phase_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_repeat_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Sits between the 4-bit debounced button bus and the board-level consumers (single-step clock, display page select, mode keys).
- Converts debounced levels into discrete press events, plus optional auto-repeat events while a button is held.
- Queues one pending event per button and shares a single valid/ready event port between the four requesters using round-robin arbitration.

Parameters:
- REPEAT_DELAY, 50000000: cycles from a press to its first auto-repeat; must be >= 2.
- REPEAT_PERIOD, 10000000: cycles between later auto-repeats; must be >= 2.
- REPEAT_MASK, 4'b0000: per-button auto-repeat enable; bit i applies to button i.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- btn_db  in  4  debounced button levels; 1 means pressed.
- evt_ready  in  1  consumer accepts the current event.
- evt_valid  out  1  an event is offered.
- evt_id  out  2  index of the button that caused the event.
- evt_repeat  out  1  1 = auto-repeat event, 0 = press event.
- pending  out  4  per-button pending flags (for debug LEDs).
- overflow  out  1  sticky flag: an event was merged into an already-pending one.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: evt_valid, evt_id, evt_repeat, pending and overflow are all 0.
  - Internal: btn_prev = 0, state = IDLE, last_grant = 3, repeat timer = 0.
  - A button held through reset therefore produces one press event after reset.
- Edge detect:
  - btn_prev <= btn_db every cycle.
  - rise[i] = btn_db[i] & ~btn_prev[i].
  - Falling edges generate no event.
- Pending set:
  - rise[i] sets pending[i] and clears rep[i].
  - A repeat tick sets pending[i] and sets rep[i], unless rise[i] occurs in the same cycle; a press wins.
- Merge:
  - A set request for a button that is already pending, and is not being taken this cycle, sets overflow = 1.
  - The flag stays pending; the two events merge into one.
  - overflow is cleared only by rst.
- Set and take in the same cycle for the same button: pending stays 1 (the new event is kept); overflow is not set.
- FSM, IDLE:
  - If any pending bit is set, select the first set index scanning last_grant+1, last_grant+2, … (mod 4).
  - On the next edge: load evt_id and evt_repeat (from rep[id]), clear pending[id], assert evt_valid, go to OFFER.
- FSM, OFFER:
  - evt_id and evt_repeat hold stable while evt_valid=1 and evt_ready=0.
  - When evt_valid & evt_ready is sampled: next edge sets evt_valid = 0, last_grant = evt_id, go to IDLE.
- Latency: a rise sampled at edge t sets pending at edge t+1 and raises evt_valid at edge t+2 (state IDLE, no contention).
- Throughput: at most one event every 2 cycles.
- Auto-repeat selection:
  - One shared 32-bit timer.
  - rep_id is the lowest-index button with btn_db[i] & REPEAT_MASK[i].
  - The timer resets to 0 on any edge (rise or fall) of a masked button, and whenever no masked button is held.
- Auto-repeat timing:
  - The first tick for rep_id occurs REPEAT_DELAY cycles after the press's pending-set edge.
  - Later ticks occur every REPEAT_PERIOD cycles after that.
  - The timer wraps to 0 at each tick; a phase bit selects DELAY or PERIOD and is cleared on timer reset.
- Unmasked buttons never repeat.
- Timer arithmetic is unsigned 32-bit; compare against parameter-1. No overflow is possible for legal parameters.
- Reset mid-OFFER: the offered event is dropped; evt_valid = 0 after the reset edge.
- evt_ready while evt_valid=0 is ignored.

Test Plan:
- Single press, no contention:
  - Stimulus: btn_db 0000->0001, evt_ready=1.
  - Response: evt_valid high exactly 1 cycle, 2 edges after the rise, with evt_id=0 and evt_repeat=0; pending returns to 0000.
- Simultaneous presses, round-robin:
  - Stimulus: btn_db 0000->1010, evt_ready=1, from reset.
  - Response: events id=1 then id=3, 2 cycles apart.
  - Then press 0011 (after releasing all): events id=0 then id=1; overflow stays 0.
- Backpressure and merge:
  - Stimulus: evt_ready=0; press btn2, release, press btn2 again while the first event is still offered.
  - Response: evt_id=2 stable throughout the stall.
  - Second press: pending[2]=1, no overflow.
  - A third press while pending[2]=1 sets overflow=1.
  - Raising evt_ready yields exactly two id=2 events.
- Auto-repeat:
  - Setup: REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_MASK=0001; hold btn0 60 cycles, evt_ready=1.
  - Response: one press event, then repeat events (evt_repeat=1) whose pending sets occur at +20, +28, +36, +44, +52 cycles after the press pending set.
  - Releasing btn0 stops repeats; holding btn1 (unmasked) gives a single event only.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while evt_valid=1 (evt_ready=0), overflow=1 and btn_db=0100 held.
  - Response: all outputs 0 after the reset edge.
  - Then one press event with id=2 at 2 edges after reset release, with no repeat when REPEAT_MASK[2]=0.
